axi4_lite_master_bridge: RTL and testbench

- Single-outstanding AXI4-Lite master that turns a simple command/response interface into AXI4-Lite write and read transactions.
- Drives the LSTM register-map slave: loads weights, biases, C/h/x inputs, and reads back y_out/C_out.
- Sits between a host-side sequencer (test controller or soft CPU) and the slave's AXI4-Lite port.
- One transaction is in flight at a time; commands are accepted only when the previous response has been consumed.

---
 rtl/axi4_lite_pkg.sv | 33 +++
 rtl/axi4_lite_master_bridge_if.sv | 41 ++++
 rtl/axi4_lite_master_bridge.sv | 213 +++++++++++++++++++++
 tb/tb_axi4_lite_master_bridge.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - AXI4-Lite response codes, bridge FSM states and LSTM register map
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_RSP
    } state_t;

    // LSTM register map shared by sequencers and benches
    localparam int unsigned ADDRESS_STEP = 4;
    localparam logic [31:0] WEIGHT_BASE  = 32'h0000_0000;
    localparam logic [31:0] BIAS_BASE    = 32'h0000_0100;
    localparam logic [31:0] C_IN_BASE    = 32'h0000_0200;
    localparam logic [31:0] H_IN_BASE    = 32'h0000_0300;
    localparam logic [31:0] X_IN_BASE    = 32'h0000_0400;
    localparam logic [31:0] Y_OUT_BASE   = 32'h0000_0500;
    localparam logic [31:0] C_OUT_BASE   = 32'h0000_0600;

    // Byte address of the index-th word inside a register region
    function automatic logic [31:0] reg_addr(input logic [31:0] base, input int unsigned index);
        return base + 32'(index * ADDRESS_STEP);
    endfunction

endpackage

// File: rtl/axi4_lite_master_bridge_if.sv
// rtl/axi4_lite_master_bridge_if.sv - AXI4-Lite bus bundle with master/slave views
interface axi4_lite_master_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi4_lite_master_bridge.sv
// rtl/axi4_lite_master_bridge.sv - single-outstanding command/response to AXI4-Lite master
module axi4_lite_master_bridge
    import axi4_lite_pkg::*;
#(
    parameter int         ADDR_WIDTH    = 32,
    parameter int         DATA_WIDTH    = 32,
    parameter logic [2:0] PROT          = 3'b000,
    parameter int         ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDR_WIDTH-1:0]    cmd_addr,
    input  logic [DATA_WIDTH-1:0]    cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]  cmd_wstrb,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_write,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic [1:0]               rsp_resp,
    output logic                     busy,
    output logic [ERR_CNT_WIDTH-1:0] error_count,
    axi4_lite_master_bridge_if.master m_axi
);

    state_t                     state_q, state_d;
    logic                       cmd_ready_q, cmd_ready_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0]    wstrb_q, wstrb_d;
    logic                       awvalid_q, awvalid_d;
    logic                       wvalid_q, wvalid_d;
    logic                       aw_done_q, aw_done_d;
    logic                       w_done_q, w_done_d;
    logic                       bready_q, bready_d;
    logic                       arvalid_q, arvalid_d;
    logic                       rready_q, rready_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic                       rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0]      rsp_data_q, rsp_data_d;
    logic [1:0]                 rsp_resp_q, rsp_resp_d;
    logic [ERR_CNT_WIDTH-1:0]   err_q, err_d;

    logic aw_hs, w_hs, aw_fin, w_fin;

    // Next-state logic: FSM transitions, per-channel done tracking and response capture
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_data_d  = rsp_data_q;
        rsp_resp_d  = rsp_resp_q;
        err_d       = err_q;

        aw_hs  = awvalid_q && m_axi.awready;
        w_hs   = wvalid_q && m_axi.wready;
        aw_fin = aw_done_q || aw_hs;
        w_fin  = w_done_q || w_hs;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    if (cmd_write) begin
                        state_d   = ST_WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_WR_REQ: begin
                // Each channel drops valid right after its own handshake
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                aw_done_d = aw_fin;
                w_done_d  = w_fin;
                if (aw_fin && w_fin) begin
                    state_d   = ST_WR_RESP;
                    bready_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            ST_WR_RESP: begin
                if (bready_q && m_axi.bvalid) begin
                    state_d     = ST_RSP;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_resp_d  = m_axi.bresp;
                end
            end
            ST_RD_REQ: begin
                if (arvalid_q && m_axi.arready) begin
                    state_d   = ST_RD_RESP;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            ST_RD_RESP: begin
                if (rready_q && m_axi.rvalid) begin
                    state_d     = ST_RSP;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_data_d  = m_axi.rdata;
                    rsp_resp_d  = m_axi.rresp;
                end
            end
            ST_RSP: begin
                // cmd_ready only rises once back in IDLE, so no same-cycle reuse
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b0;
            end
        endcase

        // Count each non-OKAY response once, on the way into RSP
        if ((state_d == ST_RSP) && (state_q != ST_RSP) &&
            (rsp_resp_d != RESP_OKAY) && (err_q != '1)) begin
            err_d = err_q + 1'b1;
        end
    end

    // State and registered outputs; reset abandons any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_data_q  <= rsp_data_d;
            rsp_resp_q  <= rsp_resp_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_resp      = rsp_resp_q;
    assign busy          = (state_q != ST_IDLE);
    assign error_count   = err_q;

    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = PROT;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arprot  = PROT;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// tb/tb_axi4_lite_master_bridge.sv - directed vector bench for the AXI4-Lite master bridge
module tb_axi4_lite_master_bridge;
    import axi4_lite_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_ready = 1'b0;

    logic        cmd_ready, rsp_valid, rsp_write, busy;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic [7:0]  error_count;

    logic        cmd_ready2, rsp_valid2, rsp_write2, busy2;
    logic [31:0] rsp_data2;
    logic [1:0]  rsp_resp2;
    logic [1:0]  error_count2;

    always #5 clk = ~clk;

    axi4_lite_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    axi4_lite_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

    // The narrow-counter instance sees exactly the same slave responses
    assign bus2.awready = bus.awready;
    assign bus2.wready  = bus.wready;
    assign bus2.bresp   = bus.bresp;
    assign bus2.bvalid  = bus.bvalid;
    assign bus2.arready = bus.arready;
    assign bus2.rdata   = bus.rdata;
    assign bus2.rresp   = bus.rresp;
    assign bus2.rvalid  = bus.rvalid;

    axi4_lite_master_bridge dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_data(rsp_data), .rsp_resp(rsp_resp), .busy(busy),
        .error_count(error_count), .m_axi(bus)
    );

    axi4_lite_master_bridge #(.ERR_CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_write(rsp_write2),
        .rsp_data(rsp_data2), .rsp_resp(rsp_resp2), .busy(busy2),
        .error_count(error_count2), .m_axi(bus2)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        int          ar_dly;
        int          resp_dly;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [31:0] exp_data;
        int          exp_lat;
        logic [7:0]  exp_err;
        logic [1:0]  exp_err2;
    } vec_t;

    vec_t vecs[10];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_slave();
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = 2'b00;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rresp   = 2'b00;
        bus.rdata   = '0;
    endtask

    // Issue one command from IDLE, play the slave with the vector's delays, check the response
    task automatic run_vec(input int idx, input vec_t v);
        int cyc = 0, t_acc = -1, t_rsp = -1;
        int awc = 0, wc = 0, arc = 0, awh = 0, wh = 0, arh = 0;
        int aw_wait = 0, w_wait = 0, ar_wait = 0, x_wait = 0;
        bit acc = 0, done = 0, stable = 1;
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_wstrb = v.strb;
        rsp_ready = 1'b0;
        while (!done && cyc < 60) begin
            if (rsp_valid) begin
                t_rsp = cyc;
                done  = 1;
                check($sformatf("v%0d_rsp_write", idx), 32'(rsp_write), 32'(v.wr));
                check($sformatf("v%0d_rsp_data", idx), rsp_data, v.exp_data);
                check($sformatf("v%0d_rsp_resp", idx), 32'(rsp_resp), 32'(v.resp));
                check($sformatf("v%0d_err_cnt", idx), 32'(error_count), 32'(v.exp_err));
                check($sformatf("v%0d_err_cnt_w2", idx), 32'(error_count2), 32'(v.exp_err2));
                check($sformatf("v%0d_rsp2_data", idx), rsp_data2, v.exp_data);
                rsp_ready = 1'b1;
            end
            if (bus.awvalid) begin
                awc++;
                if (bus.awaddr !== v.addr || bus.awprot !== 3'b000) stable = 0;
                bus.awready = (aw_wait >= v.aw_dly);
                aw_wait++;
                if (bus.awready) awh++;
            end else begin
                bus.awready = 1'b0;
            end
            if (bus.wvalid) begin
                wc++;
                if (bus.wdata !== v.wdata || bus.wstrb !== v.strb) stable = 0;
                bus.wready = (w_wait >= v.w_dly);
                w_wait++;
                if (bus.wready) wh++;
            end else begin
                bus.wready = 1'b0;
            end
            if (bus.arvalid) begin
                arc++;
                if (bus.araddr !== v.addr || bus.arprot !== 3'b000) stable = 0;
                bus.arready = (ar_wait >= v.ar_dly);
                ar_wait++;
                if (bus.arready) arh++;
            end else begin
                bus.arready = 1'b0;
            end
            bus.bresp  = v.resp;
            bus.rresp  = v.resp;
            bus.rdata  = v.rdata;
            bus.bvalid = bus.bready && (x_wait >= v.resp_dly);
            bus.rvalid = bus.rready && (x_wait >= v.resp_dly);
            if (bus.bready || bus.rready) x_wait++;
            if (acc) begin
                cmd_valid = 1'b0;
            end else if (cmd_valid && cmd_ready) begin
                acc   = 1;
                t_acc = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        check($sformatf("v%0d_rsp_seen", idx), 32'(done), 32'd1);
        check($sformatf("v%0d_latency", idx), 32'(t_rsp - t_acc), 32'(v.exp_lat));
        check($sformatf("v%0d_bus_stable", idx), 32'(stable), 32'd1);
        if (v.wr) begin
            check($sformatf("v%0d_aw_hs", idx), 32'(awh), 32'd1);
            check($sformatf("v%0d_w_hs", idx), 32'(wh), 32'd1);
            check($sformatf("v%0d_awvalid_cycles", idx), 32'(awc), 32'(v.aw_dly + 1));
            check($sformatf("v%0d_wvalid_cycles", idx), 32'(wc), 32'(v.w_dly + 1));
            check($sformatf("v%0d_no_ar", idx), 32'(arc), 32'd0);
        end else begin
            check($sformatf("v%0d_ar_hs", idx), 32'(arh), 32'd1);
            check($sformatf("v%0d_arvalid_cycles", idx), 32'(arc), 32'(v.ar_dly + 1));
            check($sformatf("v%0d_no_aw", idx), 32'(awc + wc), 32'd0);
        end
        cmd_valid = 1'b0;
        clear_slave();
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // Complete whatever transaction is in flight with a zero-wait slave
    task automatic drain(input string name, input logic exp_write);
        int  cyc = 0;
        bit  seen = 0;
        while (!seen && cyc < 30) begin
            if (rsp_valid) begin
                seen = 1;
                check(name, 32'(rsp_write), 32'(exp_write));
                rsp_ready = 1'b1;
            end
            bus.awready = bus.awvalid;
            bus.wready  = bus.wvalid;
            bus.arready = bus.arvalid;
            bus.bvalid  = bus.bready;
            bus.rvalid  = bus.rready;
            @(negedge clk);
            cyc++;
        end
        check({name, "_seen"}, 32'(seen), 32'd1);
        clear_slave();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int t;
        clear_slave();

        //          wr    addr                      wdata         strb  aw w  ar rd  resp   rdata         exp_data      lat err  err2
        vecs[0] = '{1'b1, 32'h0000_0010,            32'h0000_1234, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0,        32'h0,        3, 8'd0, 2'd0};
        vecs[1] = '{1'b1, 32'h0000_0014,            32'hA5A5_0001, 4'h3, 3, 0, 0, 0, 2'b00, 32'h0,        32'h0,        6, 8'd0, 2'd0};
        vecs[2] = '{1'b0, reg_addr(BIAS_BASE, 1),   32'h0,         4'h0, 0, 0, 0, 2, 2'b00, 32'h0000_BEEF, 32'h0000_BEEF, 5, 8'd0, 2'd0};
        vecs[3] = '{1'b1, 32'h0000_0020,            32'h0000_0077, 4'hF, 0, 0, 0, 0, 2'b10, 32'h0,        32'h0,        3, 8'd1, 2'd1};
        vecs[4] = '{1'b0, 32'h0000_0504,            32'h0,         4'h0, 0, 0, 0, 0, 2'b11, 32'h1111_2222, 32'h1111_2222, 3, 8'd2, 2'd2};
        vecs[5] = '{1'b1, 32'h0000_0208,            32'hDEAD_0000, 4'hC, 1, 1, 0, 0, 2'b11, 32'h0,        32'h0,        4, 8'd3, 2'd3};
        vecs[6] = '{1'b0, 32'h0000_0600,            32'h0,         4'h0, 0, 0, 0, 1, 2'b10, 32'h0000_00AB, 32'h0000_00AB, 4, 8'd4, 2'd3};
        vecs[7] = '{1'b1, 32'h0000_0300,            32'h0000_0001, 4'h1, 0, 0, 0, 0, 2'b01, 32'h0,        32'h0,        3, 8'd5, 2'd3};
        vecs[8] = '{1'b0, 32'h0000_0404,            32'h0,         4'h0, 0, 0, 1, 0, 2'b10, 32'h8000_0001, 32'h8000_0001, 4, 8'd6, 2'd3};
        vecs[9] = '{1'b1, 32'h0000_0108,            32'h0F0F_F0F0, 4'hF, 0, 2, 0, 1, 2'b00, 32'h0,        32'h0,        6, 8'd6, 2'd3};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_valids", 32'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err_cnt", 32'(error_count), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            run_vec(i, vecs[i]);
        end

        // Response held off for five cycles while a new command waits
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = reg_addr(C_OUT_BASE, 2);
        t = 0;
        while (!rsp_valid && t < 30) begin
            if (busy) cmd_valid = 1'b0;
            bus.arready = bus.arvalid;
            bus.rvalid  = bus.rready;
            bus.rdata   = 32'hCAFE_F00D;
            bus.rresp   = 2'b00;
            @(negedge clk);
            t++;
        end
        check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
        clear_slave();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0400;
        cmd_wdata = 32'h0000_0055;
        cmd_wstrb = 4'hF;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hold%0d_rsp_valid", k), 32'(rsp_valid), 32'd1);
            check($sformatf("hold%0d_rsp_data", k), rsp_data, 32'hCAFE_F00D);
            check($sformatf("hold%0d_rsp_meta", k), 32'({rsp_write, rsp_resp}), 32'd0);
            check($sformatf("hold%0d_cmd_ready", k), 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("release_busy", 32'(busy), 32'd0);
        check("release_cmd_ready", 32'(cmd_ready), 32'd1);
        check("release_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("next_cmd_accepted", 32'(busy), 32'd1);
        check("next_cmd_awvalid", 32'(bus.awvalid), 32'd1);
        drain("next_cmd_rsp_write", 1'b1);

        // Reset while the read address is still waiting for arready
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0500;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rdreq_arvalid", 32'(bus.arvalid), 32'd1);
        check("rdreq_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_arvalid", 32'(bus.arvalid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("midrst_err_cnt", 32'(error_count), 32'd0);
        check("midrst_err_cnt_w2", 32'(error_count2), 32'd0);
        check("midrst_no_rsp", 32'(rsp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
